// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: assembles big-endian words from a byte-wide
// instruction memory and queues {pc, word} pairs for the decode stage.
module instr_fetch_queue #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [31:0]      r_fetch_pc;
  logic [1:0]       r_cnt;
  logic [23:0]      r_asm;
  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_byte_addr;
  logic [63:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_byte_addr = r_fetch_pc + {30'd0, r_cnt};
  assign imem_addr   = w_byte_addr[ADDR_W-1:0];
  assign inst_valid  = (r_count != '0);
  assign w_pop       = inst_valid && inst_ready;
  // A full queue still accepts the stalled word when the head leaves this cycle.
  assign w_push      = (r_cnt == 2'd3) && ((r_count != FULL) || w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign inst_pc     = inst_valid ? w_head[63:32] : '0;
  assign inst        = inst_valid ? w_head[31:0]  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_cnt      <= '0;
      r_asm      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_cnt      <= '0;
      r_asm      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (r_cnt != 2'd3) begin
        case (r_cnt)
          2'd0:    r_asm[23:16] <= imem_rdata;
          2'd1:    r_asm[15:8]  <= imem_rdata;
          default: r_asm[7:0]   <= imem_rdata;
        endcase
        r_cnt <= r_cnt + 2'd1;
      end else if (w_push) begin
        r_mem[r_wr_ptr] <= {r_fetch_pc, r_asm, imem_rdata};
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
        r_fetch_pc      <= r_fetch_pc + 32'd4;
        r_cnt           <= '0;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
